// File: rtl/fill_valve_arbiter.sv
// Round-robin arbiter sharing one water inlet among N_MACH machines, with a
// bounded hold time, a closed-valve dead gap between grants and emergency stop.
module fill_valve_arbiter #(
  parameter int N_MACH   = 4,
  parameter int MAX_HOLD = 8,
  parameter int GAP      = 2,
  parameter int CNT_W    = 4,
  localparam int ID_W    = $clog2(N_MACH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_MACH-1:0] fill_req,
  input  logic [N_MACH-1:0] fill_done,
  input  logic              estop,
  output logic [N_MACH-1:0] grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              main_valve,
  output logic              busy,
  output logic              timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic [CNT_W-1:0]   gap_cnt, gap_nxt;
  logic [N_MACH-1:0]  grant_nxt;
  logic [ID_W-1:0]    grant_id_nxt;
  logic               timeout_nxt;
  logic [ID_W-1:0]    sel;
  logic               sel_ok;
  logic [ID_W:0]      pos;
  logic               cur_done, cur_req, hold_end, release_now, hold_only;

  // Round-robin search starting at the pointer, wrapping past N_MACH-1.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    pos    = '0;
    for (int i = 0; i < N_MACH; i++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(i);
      if (pos >= (ID_W+1)'(N_MACH)) pos = pos - (ID_W+1)'(N_MACH);
      if (!sel_ok && fill_req[pos[ID_W-1:0]]) begin
        sel    = pos[ID_W-1:0];
        sel_ok = 1'b1;
      end
    end
  end

  assign cur_done    = fill_done[grant_id];
  assign cur_req     = fill_req[grant_id];
  assign hold_end    = (hold_cnt == HOLD_LAST);
  assign release_now = cur_done | ~cur_req | hold_end;
  assign hold_only   = hold_end & ~cur_done & cur_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      grant      <= '0;
      grant_id   <= '0;
      main_valve <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      hold_cnt   <= hold_nxt;
      gap_cnt    <= gap_nxt;
      grant      <= grant_nxt;
      grant_id   <= grant_id_nxt;
      main_valve <= |grant_nxt;
      busy       <= (state_nxt != S_IDLE);
      timeout    <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sel_ok) state_nxt = S_GRANT;
      S_GRANT: if (release_now) state_nxt = S_GAP;
      S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (estop) state_nxt = S_IDLE;
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    ptr_nxt      = ptr;
    hold_nxt     = hold_cnt;
    gap_nxt      = gap_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_ok && !estop) begin
          grant_nxt      = '0;
          grant_nxt[sel] = 1'b1;
          grant_id_nxt   = sel;
          ptr_nxt        = (sel == ID_W'(N_MACH - 1)) ? '0 : sel + 1'b1;
          hold_nxt       = '0;
        end
      end
      S_GRANT: begin
        hold_nxt = hold_cnt + 1'b1;
        if (release_now) begin
          grant_nxt   = '0;
          gap_nxt     = '0;
          timeout_nxt = hold_only;
        end
      end
      S_GAP:   gap_nxt = gap_cnt + 1'b1;
      default: grant_nxt = '0;
    endcase
    if (estop) begin
      grant_nxt   = '0;
      timeout_nxt = 1'b0;
    end
  end

endmodule
